// File: rtl/crc32_pkg.sv
// Shared constants and the 1-bit update for the reflected IEEE 802.3 CRC-32.
package crc32_pkg;

  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_XOROUT    = 32'hFFFFFFFF;

  typedef struct packed {
    logic [31:0] crc;
    logic        valid;
  } crc32_res_t;

  function automatic logic [31:0] crc32_step_bit(
    input logic [31:0] c,
    input logic        d
  );
    logic [31:0] s;
    s = c >> 1;
    if (c[0] ^ d) begin
      s = s ^ CRC32_POLY_REFL;
    end
    return s;
  endfunction

endpackage

// File: rtl/crc32_word_step.sv
// Combinational fold of one 32-bit word into a reflected CRC-32 state.
module crc32_word_step
  import crc32_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [31:0] data,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  // Bit 0 enters first: little-endian bytes, LSB first within each byte.
  always_comb begin
    c = crc_in;
    for (int i = 0; i < 32; i++) begin
      c = crc32_step_bit(c, data[i]);
    end
  end

  assign crc_out = c;

endmodule

// File: rtl/crc32.sv
// Streaming CRC-32 accumulator: one word per clock, registered finalized CRC.
module crc32
  import crc32_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_in,
  input  logic        input_valid,
  output logic [31:0] crc32_out,
  output logic        output_valid
);

  logic [31:0] crc_state_q;
  logic [31:0] crc_state_d;
  logic [31:0] crc_next;
  crc32_res_t  res_q;
  crc32_res_t  res_d;

  crc32_word_step u_step (
    .crc_in  (crc_state_q),
    .data    (data_in),
    .crc_out (crc_next)
  );

  always_comb begin
    crc_state_d = crc_state_q;
    res_d.crc   = res_q.crc;
    res_d.valid = 1'b0;
    if (input_valid) begin
      crc_state_d = crc_next;
      res_d.crc   = crc_next ^ CRC32_XOROUT;
      res_d.valid = 1'b1;
    end
  end

  // Reset overrides a simultaneous valid word, discarding it.
  always_ff @(posedge clk) begin
    if (reset) begin
      crc_state_q <= CRC32_INIT;
      res_q.crc   <= 32'h0;
      res_q.valid <= 1'b0;
    end else begin
      crc_state_q <= crc_state_d;
      res_q       <= res_d;
    end
  end

  assign crc32_out    = res_q.crc;
  assign output_valid = res_q.valid;

endmodule

// File: tb/tb_crc32.sv
// Randomized self-checking bench for crc32 against a byte-wise software CRC.
module tb_crc32;

  logic        clk;
  logic        reset;
  logic [31:0] data_in;
  logic        input_valid;
  logic [31:0] crc32_out;
  logic        output_valid;

  int n_tests;
  int n_fail;

  logic [7:0]  msg[$];
  logic [31:0] final_b2b;
  logic [31:0] held;
  int          pulses;

  crc32 dut (
    .clk          (clk),
    .reset        (reset),
    .data_in      (data_in),
    .input_valid  (input_valid),
    .crc32_out    (crc32_out),
    .output_valid (output_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sw_crc(input logic [7:0] q[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (q[i]) begin
      c = c ^ {24'h0, q[i]};
      for (int k = 0; k < 8; k++) begin
        if (c[0]) c = (c >> 1) ^ 32'hEDB88320;
        else      c = c >> 1;
      end
    end
    return ~c;
  endfunction

  task automatic push_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) begin
      msg.push_back(w[8*b +: 8]);
    end
  endtask

  // Drive one cycle at the falling edge, then sample just after the rising edge.
  task automatic cyc(input logic r, input logic v, input logic [31:0] d);
    @(negedge clk);
    reset       = r;
    input_valid = v;
    data_in     = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 32'h0);
    msg.delete();
  endtask

  task automatic single(input string tag, input logic [31:0] w, input logic [31:0] exp);
    do_reset(1);
    cyc(1'b0, 1'b1, w);
    chk({tag, "_valid"}, {31'h0, output_valid}, 32'h1);
    chk({tag, "_crc"}, crc32_out, exp);
    cyc(1'b0, 1'b0, $urandom);
    chk({tag, "_pulse"}, {31'h0, output_valid}, 32'h0);
    chk({tag, "_hold"}, crc32_out, exp);
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    reset       = 1'b1;
    input_valid = 1'b0;
    data_in     = 32'h0;

    do_reset(2);
    chk("rst_crc", crc32_out, 32'h0);
    chk("rst_valid", {31'h0, output_valid}, 32'h0);
    cyc(1'b0, 1'b0, 32'hDEADBEEF);
    cyc(1'b0, 1'b0, 32'h0);
    chk("idle_crc", crc32_out, 32'h0);
    chk("idle_valid", {31'h0, output_valid}, 32'h0);

    single("zero", 32'h00000000, 32'h2144DF1C);
    single("ones", 32'hFFFFFFFF, 32'hFFFFFFFF);
    single("abcd", 32'h64636261, 32'hED82CD11);

    for (int t = 0; t < 4; t++) begin
      logic [31:0] w;
      w = $urandom;
      do_reset(1);
      push_word(w);
      cyc(1'b0, 1'b1, w);
      chk("rand_single", crc32_out, sw_crc(msg));
    end

    do_reset(2);
    for (int i = 0; i <= 100; i++) begin
      logic [31:0] w;
      w = 32'h12345678 + i;
      push_word(w);
      cyc(1'b0, 1'b1, w);
      chk("b2b_valid", {31'h0, output_valid}, 32'h1);
      chk("b2b_crc", crc32_out, sw_crc(msg));
    end
    final_b2b = sw_crc(msg);
    cyc(1'b0, 1'b0, $urandom);
    chk("b2b_end_valid", {31'h0, output_valid}, 32'h0);
    chk("b2b_end_hold", crc32_out, final_b2b);

    do_reset(1);
    pulses = 0;
    held   = 32'h0;
    for (int i = 0; i <= 100; i++) begin
      int gap;
      logic [31:0] w;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        cyc(1'b0, 1'b0, $urandom);
        chk("gap_idle_valid", {31'h0, output_valid}, 32'h0);
        chk("gap_idle_hold", crc32_out, held);
      end
      w = 32'h12345678 + i;
      push_word(w);
      cyc(1'b0, 1'b1, w);
      if (output_valid) pulses++;
      held = crc32_out;
    end
    chk("gap_pulses", pulses, 101);
    chk("gap_final", crc32_out, final_b2b);

    do_reset(1);
    for (int i = 0; i < 5; i++) begin
      logic [31:0] w;
      w = $urandom;
      push_word(w);
      cyc(1'b0, 1'b1, w);
    end
    chk("mid_pre", crc32_out, sw_crc(msg));
    cyc(1'b1, 1'b1, 32'hCAFEF00D);
    msg.delete();
    chk("mid_rst_crc", crc32_out, 32'h0);
    chk("mid_rst_valid", {31'h0, output_valid}, 32'h0);
    cyc(1'b0, 1'b1, 32'h00000000);
    chk("mid_fresh", crc32_out, 32'h2144DF1C);
    chk("mid_fresh_valid", {31'h0, output_valid}, 32'h1);
    push_word(32'h00000000);
    push_word(32'h64636261);
    cyc(1'b0, 1'b1, 32'h64636261);
    chk("mid_chain", crc32_out, sw_crc(msg));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
